fir_tn: RTL and testbench

Parametrised, signed, N-tap transposed-form FIR filter with a streaming valid/ready interface, run-time loadable coefficients and a synchronous flush. It is the next generation of our fixed 3-tap Booth-multiplier FIR top. Tap count, data width and coefficient width are generics. The pipeline advances only on accepted samples, and the output is registered behind a one-entry skid-free holding stage.

---
 rtl/fir_tn.sv | 106 ++++++++++
 tb/tb_fir_tn.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tn.sv
// Signed N-tap transposed-form FIR with valid/ready streaming, run-time
// loadable coefficients, synchronous flush and a one-entry output register.
module fir_tn #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 4,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   x,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    y
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int AW     = $clog2(NTAPS);

  logic signed [COEF_W-1:0] c_q [NTAPS];
  logic signed [COEF_W-1:0] c_d [NTAPS];
  logic signed [ACC_W-1:0]  s_q [NTAPS-1];
  logic signed [ACC_W-1:0]  s_d [NTAPS-1];
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  prod_ext [NTAPS];
  logic                     acc;

  // Flush blocks acceptance so a sample offered alongside it is dropped.
  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;

  // Full-precision signed products, then resized (sign-extend or wrap) to ACC_W.
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      logic signed [PROD_W-1:0] prod;
      assign prod         = PROD_W'(x) * PROD_W'(c_q[gi]);
      assign prod_ext[gi] = ACC_W'(prod);
    end
  endgenerate

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    for (int k = 0; k < NTAPS - 1; k++) begin
      s_d[k] = s_q[k];
    end
    if (flush) begin
      for (int k = 0; k < NTAPS - 1; k++) begin
        s_d[k] = '0;
      end
      out_valid_d = 1'b0;
    end else if (acc) begin
      y_d = prod_ext[0] + s_q[0];
      for (int k = 0; k < NTAPS - 2; k++) begin
        s_d[k] = prod_ext[k+1] + s_q[k+1];
      end
      s_d[NTAPS-2] = prod_ext[NTAPS-1];
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Products above read c_q, so a write coinciding with an accept only
  // takes effect for the following sample. Out-of-range addresses match no tap.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      c_d[k] = c_q[k];
      if (coef_we && (coef_addr == AW'(k))) begin
        c_d[k] = coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        c_q[k] <= '0;
      end
      for (int k = 0; k < NTAPS - 1; k++) begin
        s_q[k] <= '0;
      end
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        c_q[k] <= c_d[k];
      end
      for (int k = 0; k < NTAPS - 1; k++) begin
        s_q[k] <= s_d[k];
      end
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fir_tn.sv
// Scoreboard bench for fir_tn: a per-sample contribution model predicts each
// output when a sample is accepted; outputs are popped and compared on transfer.
module tb_fir_tn;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam int AW = 18;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [DW-1:0]  x = '0;
  logic                  coef_we = 1'b0;
  logic [1:0]            coef_addr = '0;
  logic signed [CW-1:0]  coef_data = '0;
  logic                  flush = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [AW-1:0]  y;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [AW-1:0]  exp_q [$];
  longint                seen  [$];
  int                    xh    [$];
  logic [NT*CW-1:0]      chh   [$];
  logic signed [CW-1:0]  c_m   [NT];
  logic [NT*CW-1:0]      snap, tmp;
  logic signed [CW-1:0]  cb;
  longint                e;

  fir_tn #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int xv);
    bit done = 1'b0;
    in_valid = 1'b1;
    x = DW'(xv);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we = 1'b1;
    coef_addr = 2'(a);
    coef_data = CW'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen.delete();
  endtask

  task automatic chk_seq(input string tag, input longint want[$]);
    chk({tag, "_count"}, longint'(seen.size()), longint'(want.size()));
    for (int i = 0; i < want.size() && i < seen.size(); i++) begin
      chk(tag, seen[i], want[i]);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      xh.delete();
      chh.delete();
      for (int k = 0; k < NT; k++) c_m[k] = '0;
    end else begin
      if (out_valid && out_ready) begin
        seen.push_back(longint'(y));
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("sb_y", longint'(y), longint'(exp_q.pop_front()));
      end
      if (flush) begin
        exp_q.delete();
        xh.delete();
        chh.delete();
      end else if (in_valid && in_ready) begin
        for (int k = 0; k < NT; k++) snap[k*CW +: CW] = c_m[k];
        xh.push_front(int'(x));
        chh.push_front(snap);
        if (xh.size() > NT) begin
          void'(xh.pop_back());
          void'(chh.pop_back());
        end
        e = 0;
        for (int j = 0; j < xh.size(); j++) begin
          tmp = chh[j];
          cb = tmp[j*CW +: CW];
          e += longint'(cb) * longint'(xh[j]);
        end
        exp_q.push_back(AW'(e));
      end
      if (coef_we) c_m[coef_addr] = coef_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint want[$];
    logic signed [AW-1:0] yh;

    repeat (3) tick();
    rst = 1'b1;
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_rdy", longint'(in_ready), 1);

    // Impulse
    for (int k = 0; k < NT; k++) wcoef(k, k + 1);
    seen.delete();
    send(1);
    chk("imp_ov", longint'(out_valid), 1);
    for (int i = 0; i < 4; i++) begin
      send(0);
      chk("imp_ov", longint'(out_valid), 1);
    end
    tick(); tick();
    want = '{1, 2, 3, 4, 0};
    chk_seq("impulse", want);

    // Signed extremes
    for (int k = 0; k < NT; k++) wcoef(k, -128);
    do_flush();
    for (int i = 0; i < 4; i++) send(-128);
    tick(); tick();
    want = '{16384, 32768, 49152, 65536};
    chk_seq("extremes", want);

    // Bubbles and backpressure
    for (int k = 0; k < NT; k++) wcoef(k, k + 1);
    do_flush();
    send(1);
    tick();
    send(0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = '0;
    yh = y;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy", longint'(in_ready), 0);
      chk("bp_y", longint'(y), longint'(yh));
      chk("bp_ov", longint'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    send(0);
    tick();
    send(0);
    tick(); tick();
    want = '{1, 2, 3, 4, 0};
    chk_seq("bubbles", want);

    // Coefficient write colliding with an accepted sample
    wcoef(0, 1); wcoef(1, 1); wcoef(2, 0); wcoef(3, 0);
    do_flush();
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'sd5;
    send(2);
    coef_we = 1'b0;
    send(2);
    tick(); tick();
    want = '{2, 12};
    chk_seq("coef_coll", want);

    // Flush drops the offered sample and clears history
    for (int k = 0; k < NT; k++) wcoef(k, 1);
    do_flush();
    send(7);
    send(7);
    flush = 1'b1;
    in_valid = 1'b1;
    x = 8'sd9;
    @(negedge clk);
    chk("flush_rdy", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_ov", longint'(out_valid), 0);
    send(1);
    chk("flush_y", longint'(y), 1);
    tick(); tick();
    want = '{7, 14, 1};
    chk_seq("flush", want);

    // Reset mid-stream clears state and coefficients
    for (int k = 0; k < NT; k++) wcoef(k, k + 1);
    do_flush();
    send(1);
    send(0);
    in_valid = 1'b1;
    x = 8'sd5;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_ov", longint'(out_valid), 0);
    chk("mid_rst_y", longint'(y), 0);
    seen.delete();
    send(1);
    for (int i = 0; i < 3; i++) send(0);
    tick(); tick();
    want = '{0, 0, 0, 0};
    chk_seq("post_rst", want);

    chk("sb_drain", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
